if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32 pipeline: owns the 9-bit PC, issues requests to a variable-latency instruction memory (one outstanding), and produces the IF/ID register contents (`Curr_Pc`, `Curr_Instr` plus a valid bit) consumed by decode. It honours stall from the hazard unit and redirect/flush from EX (taken branch, JAL/JALR), and discards in-flight responses made stale by a redirect.

---
 rtl/if_fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32 instruction fetch stage with IF/ID register; define IF_PERF_CNT_EN for fetch/bubble counters
module if_fetch_stage #(
  parameter int                 PC_W      = 9,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               ifid_valid_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt_o,
  output logic [31:0]        perf_bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic [PC_W-1:0]    redir_tgt;
  logic               buf_v_q;
  logic [PC_W-1:0]    buf_pc_q;
  logic [INSTR_W-1:0] buf_instr_q;
  logic               issue;
  logic               resp_take;
  logic               unused_bits;

  // Redirect targets are word aligned; the low two bits carry no information.
  assign redir_tgt   = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign unused_bits = ^redirect_pc_i[1:0];

  // A response that belongs to the live request and is not being flushed.
  assign resp_take = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;

  // State register: FSM, fetch PC and address of the outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next state: redirect retargets the PC and, with a request in flight, marks its response stale.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          pc_d = redir_tgt;
        end else if (issue) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_W'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_d    = redir_tgt;
          state_d = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          if (issue) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_W'(4);
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          pc_d = redir_tgt;
        end
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Request strobe: idle with an empty buffer, or back-to-back when a live response is consumed unstalled.
  always_comb begin
    issue = 1'b0;
    if (!reset && !redirect_i) begin
      case (state_q)
        S_REQ:   issue = !buf_v_q;
        S_WAIT:  issue = imem_rvalid_i && !stall_i;
        default: issue = 1'b0;
      endcase
    end
    imem_req_o  = issue;
    imem_addr_o = issue ? pc_q : '0;
  end

  // IF/ID register and one-entry buffer that parks a response arriving during stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_v_q      <= 1'b0;
      buf_pc_q     <= '0;
      buf_instr_q  <= NOP_INSTR;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_instr_o <= NOP_INSTR;
    end else if (redirect_i) begin
      buf_v_q      <= 1'b0;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_instr_o <= NOP_INSTR;
    end else if (stall_i) begin
      if (resp_take) begin
        buf_v_q     <= 1'b1;
        buf_pc_q    <= req_pc_q;
        buf_instr_q <= imem_rdata_i;
      end
    end else if (buf_v_q) begin
      buf_v_q      <= 1'b0;
      ifid_valid_o <= 1'b1;
      ifid_pc_o    <= buf_pc_q;
      ifid_instr_o <= buf_instr_q;
    end else if (resp_take) begin
      ifid_valid_o <= 1'b1;
      ifid_pc_o    <= req_pc_q;
      ifid_instr_o <= imem_rdata_i;
    end else begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Count valid IF/ID loads and bubbles inserted on unstalled, unflushed cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt_o  <= '0;
      perf_bubble_cnt_o <= '0;
    end else if (!redirect_i && !stall_i) begin
      if (buf_v_q || resp_take) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      end else begin
        perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage against a transaction-level model
module tb_if_fetch_stage;

  localparam int          PC_W    = 9;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               stall_i = 1'b0;
  logic               redirect_i = 1'b0;
  logic [PC_W-1:0]    redirect_pc_i = '0;
  logic               imem_req_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic               imem_rvalid_i = 1'b0;
  logic [INSTR_W-1:0] imem_rdata_i = '0;
  logic               ifid_valid_o;
  logic [PC_W-1:0]    ifid_pc_o;
  logic [INSTR_W-1:0] ifid_instr_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0]        perf_fetch_cnt_o;
  logic [31:0]        perf_bubble_cnt_o;
`endif

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_instr_o  (ifid_instr_o)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o  (perf_fetch_cnt_o),
    .perf_bubble_cnt_o (perf_bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instruction memory responder: one outstanding request, fixed latency.
  int              mem_lat = 1;
  bit              mem_pend = 0;
  int              mem_wait = 0;
  logic [PC_W-1:0] mem_addr = '0;
  bit              inject_en = 0;

  // Reference model: fetch pointer, outstanding transaction, parked response, IF/ID.
  logic [PC_W-1:0]    m_pc;
  bit                 m_out;
  bit                 m_stale;
  logic [PC_W-1:0]    m_out_pc;
  bit                 m_buf_v;
  logic [PC_W-1:0]    m_buf_pc;
  logic [INSTR_W-1:0] m_buf_instr;
  bit                 m_v;
  logic [PC_W-1:0]    m_ipc;
  logic [INSTR_W-1:0] m_instr;
  logic [31:0]        m_fetch;
  logic [31:0]        m_bubble;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    mem_word = {16'hC0DE, 7'd0, a};
  endfunction

  task automatic model_reset();
    m_pc = '0; m_out = 0; m_stale = 0; m_out_pc = '0;
    m_buf_v = 0; m_buf_pc = '0; m_buf_instr = NOP;
    m_v = 0; m_ipc = '0; m_instr = NOP;
    m_fetch = '0; m_bubble = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; imem_rvalid_i = 1'b0;
    #1;
    check_eq("rst_ifid_valid", ifid_valid_o, 0);
    check_eq("rst_ifid_pc", ifid_pc_o, 0);
    check_eq("rst_ifid_instr", ifid_instr_o, NOP);
    check_eq("rst_imem_req", imem_req_o, 0);
    check_eq("rst_imem_addr", imem_addr_o, 0);
`ifdef IF_PERF_CNT_EN
    check_eq("rst_perf_fetch", perf_fetch_cnt_o, 0);
    check_eq("rst_perf_bubble", perf_bubble_cnt_o, 0);
`endif
    model_reset();
    mem_pend = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the request, advance the model, check IF/ID.
  task automatic step(input bit st, input bit rd, input logic [PC_W-1:0] tgt);
    bit exp_req;
    bit resp;
    bit take;
    @(negedge clk);
    stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
    if (mem_pend && mem_wait == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_addr);
      mem_pend      = 0;
    end else begin
      if (mem_pend) mem_wait--;
      imem_rvalid_i = !mem_pend && inject_en && ($urandom_range(0, 15) == 0);
      imem_rdata_i  = $urandom;
    end
    #1;
    resp    = m_out && imem_rvalid_i;
    exp_req = 0;
    if (!rd) begin
      if (!m_out) exp_req = !m_buf_v;
      else if (!m_stale && imem_rvalid_i && !st) exp_req = 1;
    end
    check_eq("imem_req", imem_req_o, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr_o, m_pc);
    if (imem_req_o) begin
      mem_pend = 1; mem_wait = mem_lat - 1; mem_addr = imem_addr_o;
    end
    take = resp && !m_stale && !rd;
    if (rd) begin
      m_v = 0; m_ipc = '0; m_instr = NOP; m_buf_v = 0;
    end else if (st) begin
      if (take) begin
        m_buf_v = 1; m_buf_pc = m_out_pc; m_buf_instr = imem_rdata_i;
      end
    end else if (m_buf_v) begin
      m_v = 1; m_ipc = m_buf_pc; m_instr = m_buf_instr; m_buf_v = 0; m_fetch++;
    end else if (take) begin
      m_v = 1; m_ipc = m_out_pc; m_instr = imem_rdata_i; m_fetch++;
    end else begin
      m_v = 0; m_instr = NOP; m_bubble++;
    end
    if (resp) begin
      m_out = 0; m_stale = 0;
    end else if (rd && m_out) begin
      m_stale = 1;
    end
    if (exp_req) begin
      m_out = 1; m_stale = 0; m_out_pc = m_pc; m_pc = m_pc + 9'd4;
    end
    if (rd) m_pc = {tgt[PC_W-1:2], 2'b00};
    @(posedge clk);
    #1;
    check_eq("ifid_valid", ifid_valid_o, m_v);
    check_eq("ifid_pc", ifid_pc_o, m_ipc);
    check_eq("ifid_instr", ifid_instr_o, m_instr);
  endtask

  initial begin
    apply_reset();

    // 1-cycle memory streaming from 0x000.
    mem_lat = 1;
    for (int i = 0; i < 8; i++) step(0, 0, '0);
    // Stall two cycles while a response is arriving, then release.
    step(1, 0, '0);
    step(1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, '0);

    // Latency-3 memory, redirect to 0x043 while a request is in flight.
    mem_lat = 3;
    for (int i = 0; i < 10; i++) step(0, 0, '0);
    step(0, 1, 9'h043);
    for (int i = 0; i < 10; i++) step(0, 0, '0);

    // Buffer a response under stall, then redirect and stall together.
    mem_lat = 1;
    for (int i = 0; i < 3; i++) step(0, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    step(1, 1, 9'h0A0);
    for (int i = 0; i < 4; i++) step(0, 0, '0);

    // PC wrap past the top of the address space.
    step(0, 1, 9'h1F8);
    for (int i = 0; i < 6; i++) step(0, 0, '0);

    // Asynchronous reset in the middle of traffic.
    apply_reset();
    for (int i = 0; i < 4; i++) step(0, 0, '0);

    // Random traffic: varying latency, stalls, redirects, stray responses.
    inject_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mem_lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, 9'($urandom_range(0, 511)));
    end
    inject_en = 0;
    for (int i = 0; i < 8; i++) step(0, 0, '0);

`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt_o, m_fetch);
    check_eq("perf_bubble", perf_bubble_cnt_o, m_bubble);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
